pixel_streamer: RTL and testbench

Frame source for the CNN front end: holds one IMG_WIDTH×IMG_HEIGHT image in an internal single-port-write / single-port-read RAM and, on command, replays it as a raster-order pixel stream (frame_start pulse, then pixel/pixel_valid beats) that drives the sliding-window generator's pixel input directly. It is the producing end of the window block's pixel interface. A host-side write port loads the image. A downstream pause input throttles the stream without losing pixels.

---
 rtl/pixel_streamer.sv | 167 ++++++++++++++++
 tb/tb_pixel_streamer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_streamer.sv
// pixel_streamer
//   Holds one IMG_WIDTH x IMG_HEIGHT image in an internal RAM and, on start,
//   replays it in raster order as a frame_start pulse followed by
//   pixel/pixel_valid beats with their (x, y) coordinates. A host write port
//   loads the image at any time, and the pause input throttles the stream
//   without dropping pixels.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   wr_en           image RAM write strobe
//   wr_addr         write address, row-major (y*IMG_WIDTH + x)
//   wr_data         write data
//   start           begin one frame; sampled only while idle
//   pause           no new RAM read is issued while high
//   pixel_out       streamed pixel
//   pixel_valid     pixel_out/pixel_x/pixel_y valid this cycle
//   frame_start     one-cycle pulse preceding the first pixel
//   pixel_x/pixel_y coordinates of pixel_out; hold while pixel_valid is low
//   busy            high from the frame_start cycle through the last beat
//   frame_done      one-cycle pulse coincident with the last beat
module pixel_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic                  pause,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  pixel_valid,
    output logic                  frame_start,
    output logic [5:0]            pixel_x,
    output logic [5:0]            pixel_y,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int                    NUM_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int                    MEM_DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_PIXELS - 1);
    localparam logic [5:0]            LAST_X     = 6'(IMG_WIDTH - 1);

    generate
        if (MEM_DEPTH < NUM_PIXELS) begin : g_addr_check
            $error("pixel_streamer: ADDR_WIDTH too small for IMG_WIDTH*IMG_HEIGHT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SOF,
        STREAM,
        DRAIN
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [5:0]            x_cnt;
    logic [5:0]            y_cnt;
    logic                  rd_en;
    logic                  rd_last;

    // Image RAM write port: open in every state, contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        rd_last = (rd_addr == LAST_ADDR);
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SOF;
                end
            end
            SOF: begin
                state_next = STREAM;
            end
            STREAM: begin
                if (!pause) begin
                    rd_en = 1'b1;
                    if (rd_last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read address and raster coordinates advance together on each issued
    // read; the row wrap happens in the same cycle, so no bubble is inserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
        end else if (state == SOF) begin
            rd_addr <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
        end else if (rd_en) begin
            rd_addr <= rd_addr + 1'b1;
            if (x_cnt == LAST_X) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // The RAM read register doubles as pixel_out; it is read-first because
    // the write port updates mem with a non-blocking assignment on the same
    // edge. Status outputs are registered from the next state so that busy
    // and frame_start line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            pixel_valid <= rd_en;
            frame_done  <= rd_en && rd_last;
            frame_start <= (state_next == SOF);
            busy        <= (state_next != IDLE);
            if (rd_en) begin
                pixel_out <= mem[rd_addr];
                pixel_x   <= x_cnt;
                pixel_y   <= y_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pixel_streamer.sv
module tb_pixel_streamer;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int N   = W * H;
    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int MAXC = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4x4 instance
    logic          wr_en, start, pause;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] pixel_out;
    logic          pixel_valid, frame_start, busy, frame_done;
    logic [5:0]    pixel_x, pixel_y;

    pixel_streamer #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .pause(pause), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .busy(busy), .frame_done(frame_done)
    );

    // default-parameter (32x32) instance
    logic          wr_en_b, start_b, pause_b;
    logic [9:0]    wr_addr_b;
    logic [15:0]   wr_data_b;
    logic [15:0]   pixel_out_b;
    logic          pixel_valid_b, frame_start_b, busy_b, frame_done_b;
    logic [5:0]    pixel_x_b, pixel_y_b;

    pixel_streamer dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .start(start_b), .pause(pause_b), .pixel_out(pixel_out_b), .pixel_valid(pixel_valid_b),
        .frame_start(frame_start_b), .pixel_x(pixel_x_b), .pixel_y(pixel_y_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: image contents plus frame progress (pixels read so far).
    logic [DW-1:0] img [N];
    bit            in_frame;
    bit            sof_now;
    int            k;
    logic          e_valid, e_fs, e_busy, e_done;
    logic [DW-1:0] e_data;
    logic [5:0]    e_x, e_y;

    task automatic model_reset();
        in_frame = 0; sof_now = 0; k = 0;
        e_valid = 0; e_fs = 0; e_busy = 0; e_done = 0;
        e_data = '0; e_x = '0; e_y = '0;
    endtask

    // Computes the outputs of the next cycle from this cycle's inputs.
    task automatic model_step();
        bit was_sof;
        was_sof = sof_now;
        e_valid = 0;
        e_done  = 0;
        sof_now = 0;
        if (!in_frame) begin
            if (start) begin
                in_frame = 1; sof_now = 1; k = 0;
            end
        end else if (was_sof) begin
            // frame_start cycle: nothing read
        end else if (k == N) begin
            in_frame = 0;
        end else if (!pause) begin
            e_valid = 1;
            e_data  = img[k];
            e_x     = 6'(k % W);
            e_y     = 6'(k / W);
            k++;
            if (k == N) e_done = 1;
        end
        e_fs   = sof_now;
        e_busy = in_frame;
        if (wr_en) img[wr_addr] = wr_data;
    endtask

    // Per-cycle stimulus for one run
    bit            pz [MAXC];
    bit            st [MAXC];
    bit            we [MAXC];
    int            wa [MAXC];
    logic [DW-1:0] wd [MAXC];
    int            rst_cyc;

    int            done_cyc, fs_cnt, beat_cnt;
    logic [DW-1:0] got [N];

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            pz[c] = 0; st[c] = 0; we[c] = 0; wa[c] = 0; wd[c] = '0;
        end
        rst_cyc = -1;
    endtask

    task automatic check_outputs(input int c);
        chk($sformatf("c%0d pixel_valid", c), pixel_valid, e_valid);
        chk($sformatf("c%0d frame_start", c), frame_start, e_fs);
        chk($sformatf("c%0d busy", c),        busy,        e_busy);
        chk($sformatf("c%0d frame_done", c),  frame_done,  e_done);
        chk($sformatf("c%0d pixel_out", c),   pixel_out,   e_data);
        chk($sformatf("c%0d pixel_x", c),     pixel_x,     e_x);
        chk($sformatf("c%0d pixel_y", c),     pixel_y,     e_y);
    endtask

    task automatic run(input int ncyc);
        done_cyc = -1; fs_cnt = 0; beat_cnt = 0;
        for (int i = 0; i < N; i++) got[i] = 'x;
        for (int c = 0; c < ncyc; c++) begin
            if (c == rst_cyc) begin
                rst = 1; start = 0; pause = 0; wr_en = 0;
                #1;
                model_reset();
                check_outputs(c);
                @(posedge clk); #1;
                rst = 0;
                continue;
            end
            check_outputs(c);
            if (pixel_valid) begin
                if (beat_cnt < N) got[beat_cnt] = pixel_out;
                beat_cnt++;
            end
            if (frame_done)  done_cyc = c;
            if (frame_start) fs_cnt++;
            start   = st[c];
            pause   = pz[c];
            wr_en   = we[c];
            wr_addr = wa[c][AW-1:0];
            wr_data = wd[c];
            model_step();
            @(posedge clk); #1;
        end
        start = 0; pause = 0; wr_en = 0;
    endtask

    task automatic load_ramp();
        clear_stim();
        for (int a = 0; a < N; a++) begin
            we[a] = 1; wa[a] = a; wd[a] = DW'(a);
        end
        run(N);
    endtask

    typedef struct {
        logic [31:0] pause_mask;
        int          restart_cyc;
        int          exp_done;
        int          exp_fs;
        int          exp_beats;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{32'h0, -1, 18, 1, 16};
        vecs[1] = '{(32'h1 << 5) | (32'h1 << 6) | (32'h1 << 10), -1, 21, 1, 16};
        vecs[2] = '{32'h0, 8, 18, 1, 16};
        vecs[3] = '{(32'h1 << 1) | (32'h1 << 18), -1, 18, 1, 16};

        rst = 1; wr_en = 0; start = 0; pause = 0; wr_addr = '0; wr_data = '0;
        wr_en_b = 0; start_b = 0; pause_b = 0; wr_addr_b = '0; wr_data_b = '0;
        model_reset();
        for (int i = 0; i < N; i++) img[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs(-1);
        chk("reset b busy",        busy_b,        1'b0);
        chk("reset b pixel_valid", pixel_valid_b, 1'b0);
        chk("reset b pixel_out",   pixel_out_b,   16'h0);
        rst = 0;

        load_ramp();

        // table-driven frames on the ramp image
        for (int v = 0; v < 4; v++) begin
            clear_stim();
            st[0] = 1;
            if (vecs[v].restart_cyc >= 0) st[vecs[v].restart_cyc] = 1;
            for (int c = 0; c < 32; c++) pz[c] = vecs[v].pause_mask[c];
            run(26);
            chk($sformatf("v%0d done_cycle", v),  done_cyc, vecs[v].exp_done);
            chk($sformatf("v%0d frame_starts", v), fs_cnt,  vecs[v].exp_fs);
            chk($sformatf("v%0d beats", v),       beat_cnt, vecs[v].exp_beats);
            for (int j = 0; j < N; j++)
                chk($sformatf("v%0d pixel%0d", v, j), got[j], DW'(j));
        end

        // writes during streaming: addr 12 before read, addr 1 after read,
        // addr 7 in the very cycle it is read (old value expected)
        clear_stim();
        st[0] = 1;
        we[5] = 1; wa[5] = 12; wd[5] = 16'hBEEF;
        we[6] = 1; wa[6] = 1;  wd[6] = 16'hBEEF;
        we[9] = 1; wa[9] = 7;  wd[9] = 16'h1234;
        run(24);
        chk("wr pixel12 new",       got[12], 16'hBEEF);
        chk("wr pixel1 old",        got[1],  16'h0001);
        chk("wr same-cycle pixel7", got[7],  16'h0007);
        chk("wr done_cycle",        done_cyc, 18);
        load_ramp();

        // reset at cycle 9 aborts the frame; a new start gives a full frame
        clear_stim();
        st[0] = 1; rst_cyc = 9;
        run(14);
        chk("rst no frame_done", done_cyc, -1);
        chk("rst frame_starts",  fs_cnt,   1);
        clear_stim();
        st[0] = 1;
        run(24);
        chk("after rst done_cycle", done_cyc, 18);
        chk("after rst beats",      beat_cnt, 16);
        for (int j = 0; j < N; j++)
            chk($sformatf("after rst pixel%0d", j), got[j], DW'(j));

        // randomized starts, pauses and writes against the model
        for (int r = 0; r < 8; r++) begin
            clear_stim();
            for (int c = 0; c < 60; c++) begin
                pz[c] = ($urandom_range(0, 2) == 0);
                st[c] = ($urandom_range(0, 7) == 0);
                we[c] = ($urandom_range(0, 3) == 0);
                wa[c] = int'($urandom_range(0, N - 1));
                wd[c] = DW'($urandom);
            end
            st[0] = 1;
            run(60);
        end
        clear_stim();
        run(40);

        // default 32x32 instance: ramp, one frame, mid-frame start ignored
        wr_en_b = 1;
        for (int a = 0; a < 1024; a++) begin
            wr_addr_b = 10'(a);
            wr_data_b = 16'(a) ^ 16'hA500;
            @(posedge clk); #1;
        end
        wr_en_b = 0;
        begin
            int beats_b, fs_b, done_b, busy_cnt_b;
            beats_b = 0; fs_b = 0; done_b = -1; busy_cnt_b = 0;
            for (int c = 0; c < 1040; c++) begin
                if (pixel_valid_b) begin
                    if (pixel_out_b !== (16'(beats_b) ^ 16'hA500) ||
                        pixel_x_b !== 6'(beats_b % 32) || pixel_y_b !== 6'(beats_b / 32))
                        chk($sformatf("b beat%0d data/x/y", beats_b),
                            {pixel_out_b, 4'h0, pixel_x_b, pixel_y_b},
                            {16'(beats_b) ^ 16'hA500, 4'h0, 6'(beats_b % 32), 6'(beats_b / 32)});
                    beats_b++;
                end
                if (frame_start_b) fs_b++;
                if (frame_done_b)  done_b = c;
                if (busy_b)        busy_cnt_b++;
                start_b = (c == 0) || (c == 500);
                @(posedge clk); #1;
            end
            start_b = 0;
            chk("b beats",        beats_b,    1024);
            chk("b done_cycle",   done_b,     1026);
            chk("b frame_starts", fs_b,       1);
            chk("b busy_cycles",  busy_cnt_b, 1026);
            chk("b idle at end",  busy_b,     1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
